// File: rtl/mem_init_fill.sv
// Sweeps an attached single-port RAM once per accepted request, writing a selectable fill pattern.
// Optional read-back check of the whole array is compiled in with `define MEM_INIT_VERIFY_EN.
module mem_init_fill #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_val,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wrdata,
    output logic              wren,
`ifdef MEM_INIT_VERIFY_EN
    input  logic [DATA_W-1:0] rddata,
    output logic              err,
`endif
    output logic              done
);

    // One extra index bit so the verify pass can count to DEPTH for its trailing compare.
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
`ifdef MEM_INIT_VERIFY_EN
    localparam logic [CW-1:0] FINAL = CW'(DEPTH);
`endif

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        VERIFY,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [1:0]          mode_q, mode_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d;
`ifdef MEM_INIT_VERIFY_EN
    logic                err_q, err_d;
`endif

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                  input logic [DATA_W-1:0] fv,
                                                  input logic [CW-1:0]     i);
        logic [DATA_W-1:0] iv;
        iv = DATA_W'(i);
        case (m)
            2'd0:    pattern = iv;
            2'd1:    pattern = fv;
            2'd2:    pattern = DATA_W'(DEPTH - 1) - iv;
            default: pattern = iv ^ fv;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (idx_q == LAST) begin
`ifdef MEM_INIT_VERIFY_EN
                    state_d = VERIFY;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef MEM_INIT_VERIFY_EN
            VERIFY: begin
                if (idx_q == FINAL) begin
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdy  = (state_q == IDLE);
        wren = (state_q == FILL);
        done = (state_q == DONE);
    end

    // addr/wrdata are registered one cycle ahead so they simply hold once the sweep ends.
    always_comb begin
        idx_d    = idx_q;
        mode_d   = mode_q;
        fill_d   = fill_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
`ifdef MEM_INIT_VERIFY_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (en) begin
                    idx_d    = '0;
                    mode_d   = mode;
                    fill_d   = fill_val;
                    addr_d   = '0;
                    wrdata_d = pattern(mode, fill_val, '0);
`ifdef MEM_INIT_VERIFY_EN
                    err_d    = 1'b0;
`endif
                end
            end
            FILL: begin
                if (idx_q != LAST) begin
                    idx_d    = idx_q + 1'b1;
                    addr_d   = ADDR_W'(idx_q + 1'b1);
                    wrdata_d = pattern(mode_q, fill_q, idx_q + 1'b1);
                end
`ifdef MEM_INIT_VERIFY_EN
                else begin
                    idx_d  = '0;
                    addr_d = '0;
                end
`endif
            end
`ifdef MEM_INIT_VERIFY_EN
            // Read data lags the address by one cycle, so compare against the previous index.
            VERIFY: begin
                if (idx_q != FINAL) begin
                    idx_d = idx_q + 1'b1;
                end
                if ((idx_q + 1'b1) < FINAL) begin
                    addr_d = ADDR_W'(idx_q + 1'b1);
                end
                if ((idx_q != '0) && (rddata != pattern(mode_q, fill_q, idx_q - 1'b1))) begin
                    err_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            mode_q   <= '0;
            fill_q   <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
`ifdef MEM_INIT_VERIFY_EN
            err_q    <= 1'b0;
`endif
        end else begin
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            fill_q   <= fill_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
`ifdef MEM_INIT_VERIFY_EN
            err_q    <= err_d;
`endif
        end
    end

    assign addr   = addr_q;
    assign wrdata = wrdata_q;
`ifdef MEM_INIT_VERIFY_EN
    assign err    = err_q;
`endif

endmodule

// File: tb/tb_mem_init_fill.sv
// Directed bench for mem_init_fill: a 256-word instance for the main sweeps and a 16-word,
// 4-bit instance for the descending pattern; follows MEM_INIT_VERIFY_EN when it is defined.
module tb_mem_init_fill;

`ifdef MEM_INIT_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif
    localparam int DEP_A      = 256;
    localparam int DEP_B      = 16;
    localparam int EXP_DONE_A = VER ? 2 * DEP_A + 2 : DEP_A + 1;
    localparam int EXP_DONE_B = VER ? 2 * DEP_B + 2 : DEP_B + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       enA, rdyA, wrenA, doneA;
    logic [1:0] modeA;
    logic [7:0] fillA, addrA, wrdataA;
    logic       enB, rdyB, wrenB, doneB;
    logic [1:0] modeB;
    logic [3:0] fillB, wrdataB;
    logic [7:0] addrB;
`ifdef MEM_INIT_VERIFY_EN
    logic [7:0] rddataA;
    logic       errA;
    logic [3:0] rddataB;
    logic       errB;
    logic       corrupt37;
    logic [7:0] ramA [0:255];
`endif

    int         checkCount = 0;
    int         errorCount = 0;
    int         wrCount, badOrder, badData, doneCycle, doneCount, rdyLow, extra;
    logic       rdyAtEnd;
    logic [7:0] capData [0:255];

    mem_init_fill #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEP_A)) dutA (
        .clk(clk), .rst(rst), .en(enA), .rdy(rdyA), .mode(modeA), .fill_val(fillA),
        .addr(addrA), .wrdata(wrdataA), .wren(wrenA),
`ifdef MEM_INIT_VERIFY_EN
        .rddata(rddataA), .err(errA),
`endif
        .done(doneA)
    );

    mem_init_fill #(.ADDR_W(8), .DATA_W(4), .DEPTH(DEP_B)) dutB (
        .clk(clk), .rst(rst), .en(enB), .rdy(rdyB), .mode(modeB), .fill_val(fillB),
        .addr(addrB), .wrdata(wrdataB), .wren(wrenB),
`ifdef MEM_INIT_VERIFY_EN
        .rddata(rddataB), .err(errB),
`endif
        .done(doneB)
    );

    always #5 clk = ~clk;

`ifdef MEM_INIT_VERIFY_EN
    // RAM model with one-cycle read latency; optionally stores a flipped bit at word 37.
    always @(posedge clk) begin
        if (wrenA) begin
            ramA[addrA] <= (corrupt37 && addrA == 8'd37) ? (wrdataA ^ 8'h01) : wrdataA;
        end
        rddataA <= ramA[addrA];
    end
    assign rddataB = 4'h0;
`endif

    function automatic logic [7:0] expA(input logic [1:0] m, input logic [7:0] fv, input int i);
        logic [7:0] iv;
        iv = i[7:0];
        case (m)
            2'd0:    expA = iv;
            2'd1:    expA = fv;
            2'd2:    expA = 8'd255 - iv;
            default: expA = iv ^ fv;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] m, input logic [7:0] fv);
        @(negedge clk);
        enA   = 1'b1;
        modeA = m;
        fillA = fv;
        @(posedge clk);
        #1 enA = 1'b0;
    endtask

    // Observes cycles 1..maxCyc after an accept; at interCyc it pulses en with a changed mode.
    task automatic captureA(input logic [1:0] m, input logic [7:0] fv, input int maxCyc, input int interCyc);
        wrCount = 0; badOrder = 0; badData = 0; doneCycle = 0; doneCount = 0; rdyLow = 0;
        for (int c = 1; c <= maxCyc; c++) begin
            @(negedge clk);
            if (wrenA) begin
                if (addrA != wrCount[7:0] || wrCount >= DEP_A) badOrder++;
                if (wrdataA !== expA(m, fv, wrCount)) badData++;
                capData[addrA] = wrdataA;
                wrCount++;
            end
            if (doneA) begin
                doneCount++;
                if (doneCycle == 0) doneCycle = c;
            end
            if (!rdyA) rdyLow++;
            rdyAtEnd = rdyA;
            if (c == interCyc) begin
                enA   = 1'b1;
                modeA = ~m;
                fillA = ~fv;
            end else begin
                enA = 1'b0;
            end
        end
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; enA = 1'b0; modeA = 2'd0; fillA = 8'h00;
        enB = 1'b0; modeB = 2'd0; fillB = 4'h0;
`ifdef MEM_INIT_VERIFY_EN
        corrupt37 = 1'b0;
`endif
        #12;
        checkOutput("reset_rdy", rdyA, 1);
        checkOutput("reset_wren", wrenA, 0);
        checkOutput("reset_done", doneA, 0);
        checkOutput("reset_addr", addrA, 0);
        checkOutput("reset_wrdata", wrdataA, 0);
        checkOutput("reset_rdyB", rdyB, 1);
`ifdef MEM_INIT_VERIFY_EN
        checkOutput("reset_err", errA, 0);
`endif
        @(negedge clk); rst = 1'b0;
        @(negedge clk);

        $display("[TB] identity fill");
        applyStimulus(2'd0, 8'h00);
        captureA(2'd0, 8'h00, EXP_DONE_A + 1, 0);
        checkOutput("id_writes", wrCount, DEP_A);
        checkOutput("id_order", badOrder, 0);
        checkOutput("id_data", badData, 0);
        checkOutput("id_last_word", capData[255], 8'hFF);
        checkOutput("id_done_cycle", doneCycle, EXP_DONE_A);
        checkOutput("id_done_count", doneCount, 1);
        checkOutput("id_rdy_low", rdyLow, EXP_DONE_A);
        checkOutput("id_rdy_after", rdyAtEnd, 1);
`ifdef MEM_INIT_VERIFY_EN
        checkOutput("id_err_clean", errA, 0);
`endif

        $display("[TB] constant fill");
        applyStimulus(2'd1, 8'hA5);
        captureA(2'd1, 8'hA5, EXP_DONE_A + 1, 0);
        checkOutput("const_writes", wrCount, DEP_A);
        checkOutput("const_data", badData, 0);
        checkOutput("const_word200", capData[200], 8'hA5);

        $display("[TB] xor fill");
        applyStimulus(2'd3, 8'h0F);
        captureA(2'd3, 8'h0F, EXP_DONE_A + 1, 0);
        checkOutput("xor_data", badData, 0);
        checkOutput("xor_word10", capData[8'h10], 8'h1F);

        $display("[TB] en pulse during sweep");
        applyStimulus(2'd0, 8'h00);
        captureA(2'd0, 8'h00, EXP_DONE_A + 1, 101);
        checkOutput("hs_data", badData, 0);
        checkOutput("hs_writes", wrCount, DEP_A);
        checkOutput("hs_done_count", doneCount, 1);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (wrenA) extra++;
        end
        checkOutput("hs_no_restart", extra, 0);

        $display("[TB] en held high");
        @(negedge clk);
        enA = 1'b1; modeA = 2'd0; fillA = 8'h00;
        @(posedge clk);
        for (int c = 1; c <= EXP_DONE_A + 2; c++) begin
            @(negedge clk);
            if (c == EXP_DONE_A) checkOutput("held_done", doneA, 1);
            if (c == EXP_DONE_A + 1) begin
                checkOutput("held_idle_rdy", rdyA, 1);
                checkOutput("held_idle_wren", wrenA, 0);
            end
            if (c == EXP_DONE_A + 2) begin
                checkOutput("held_restart_wren", wrenA, 1);
                checkOutput("held_restart_addr", addrA, 0);
            end
        end
        enA = 1'b0;
        for (int c = 0; c < 2 * EXP_DONE_A && !rdyA; c++) @(negedge clk);
        checkOutput("held_back_idle", rdyA, 1);

        $display("[TB] reset mid-sweep");
        applyStimulus(2'd0, 8'h00);
        wrCount = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (wrenA) wrCount++;
        end
        checkOutput("rst_writes_before", wrCount, 50);
        rst = 1'b1;
        #1;
        checkOutput("rst_wren", wrenA, 0);
        checkOutput("rst_rdy", rdyA, 1);
        checkOutput("rst_addr", addrA, 0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (wrenA) extra++;
        end
        checkOutput("rst_no_writes", extra, 0);
        rst = 1'b0;
        applyStimulus(2'd0, 8'h00);
        captureA(2'd0, 8'h00, EXP_DONE_A + 1, 0);
        checkOutput("rst_restart_order", badOrder, 0);
        checkOutput("rst_restart_writes", wrCount, DEP_A);

`ifdef MEM_INIT_VERIFY_EN
        $display("[TB] verify with corrupted word 37");
        corrupt37 = 1'b1;
        applyStimulus(2'd0, 8'h00);
        captureA(2'd0, 8'h00, EXP_DONE_A + 1, 0);
        checkOutput("ver_err_set", errA, 1);
        checkOutput("ver_done_cycle", doneCycle, EXP_DONE_A);
        repeat (3) @(negedge clk);
        checkOutput("ver_err_sticky", errA, 1);
        corrupt37 = 1'b0;
        applyStimulus(2'd0, 8'h00);
        @(negedge clk);
        checkOutput("ver_err_cleared", errA, 0);
        repeat (EXP_DONE_A) @(negedge clk);
        checkOutput("ver_err_clean_end", errA, 0);
`endif

        $display("[TB] descending fill on 16x4 instance");
        @(negedge clk);
        enB = 1'b1; modeB = 2'd2; fillB = 4'h0;
        @(posedge clk);
        #1 enB = 1'b0;
        wrCount = 0; badData = 0; badOrder = 0; doneCycle = 0;
        for (int c = 1; c <= EXP_DONE_B + 1; c++) begin
            @(negedge clk);
            if (wrenB) begin
                if (wrCount == 0) checkOutput("desc_first", {addrB, wrdataB}, {8'd0, 4'hF});
                if (wrCount == 15) checkOutput("desc_last", {addrB, wrdataB}, {8'd15, 4'h0});
                if (addrB >= 8'd16) badOrder++;
                if (wrdataB !== 4'(15 - wrCount)) badData++;
                wrCount++;
            end
            if (doneB && doneCycle == 0) doneCycle = c;
        end
        checkOutput("desc_writes", wrCount, DEP_B);
        checkOutput("desc_out_of_range", badOrder, 0);
        checkOutput("desc_data", badData, 0);
        checkOutput("desc_done_cycle", doneCycle, EXP_DONE_B);
        checkOutput("desc_rdy_after", rdyB, 1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
